// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants for the 640x480 @ 60 Hz scan on the Nexys-4.
// The block controller takes its visible-window bounds from here as well,
// so the window is defined in exactly one place.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int CLK_DIV     = 4;
  localparam int H_SYNC      = 96;
  localparam int H_VIS_START = 144;
  localparam int H_VIS_END   = 783;
  localparam int H_TOTAL     = 800;
  localparam int V_SYNC      = 2;
  localparam int V_VIS_START = 35;
  localparam int V_VIS_END   = 514;
  localparam int V_TOTAL     = 525;

  // Board clocks per complete frame (one frame_tick period).
  localparam int FRAME_CLKS = CLK_DIV * H_TOTAL * V_TOTAL;

  typedef logic [CNT_W-1:0] cnt_t;

  // Inclusive range test used for the visible-window decode.
  function automatic logic in_span(cnt_t val, cnt_t lo, cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: one-clock tick every DIV clocks. Also drives the
// slower move-tick divider. tick_next is the value tick will take on the
// coming edge, so a consumer can register a decode that lines up with tick.
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic tick_next
);

  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  // Next divider count: wrap after LAST (also recovers any stray value).
  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q >= LAST) div_d = '0;
  end

  assign tick_next = (div_d == LAST);

  // Divider count and registered tick, high while the count sits at LAST.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= '0;
      tick  <= 1'b0;
    end else begin
      div_q <= div_d;
      tick  <= tick_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-enable divider, 800x525 column/line counters
// and registered sync/bright/frame_tick decode. Decodes are taken from the
// next-state counters so every pin agrees with hCount/vCount each cycle.
module vga_timing_gen #(
  parameter int CLK_DIV     = vga_timing_pkg::CLK_DIV,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_VIS_START = vga_timing_pkg::H_VIS_START,
  parameter int H_VIS_END   = vga_timing_pkg::H_VIS_END,
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_VIS_START = vga_timing_pkg::V_VIS_START,
  parameter int V_VIS_END   = vga_timing_pkg::V_VIS_END,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             pix_tick,
  output logic [vga_timing_pkg::CNT_W-1:0] hCount,
  output logic [vga_timing_pkg::CNT_W-1:0] vCount,
  output logic                             bright,
  output logic                             hSync,
  output logic                             vSync,
  output logic                             frame_tick
);

  localparam vga_timing_pkg::cnt_t H_LAST  = vga_timing_pkg::cnt_t'(H_TOTAL - 1);
  localparam vga_timing_pkg::cnt_t V_LAST  = vga_timing_pkg::cnt_t'(V_TOTAL - 1);
  localparam vga_timing_pkg::cnt_t H_SYN_C = vga_timing_pkg::cnt_t'(H_SYNC);
  localparam vga_timing_pkg::cnt_t V_SYN_C = vga_timing_pkg::cnt_t'(V_SYNC);
  localparam vga_timing_pkg::cnt_t H_VS_C  = vga_timing_pkg::cnt_t'(H_VIS_START);
  localparam vga_timing_pkg::cnt_t H_VE_C  = vga_timing_pkg::cnt_t'(H_VIS_END);
  localparam vga_timing_pkg::cnt_t V_VS_C  = vga_timing_pkg::cnt_t'(V_VIS_START);
  localparam vga_timing_pkg::cnt_t V_VE_C  = vga_timing_pkg::cnt_t'(V_VIS_END);

  logic                 tick_next;
  vga_timing_pkg::cnt_t h_nxt;
  vga_timing_pkg::cnt_t v_nxt;

  clk_en_div #(.DIV(CLK_DIV)) u_pix_div (
    .clk       (clk),
    .rst       (rst),
    .tick      (pix_tick),
    .tick_next (tick_next)
  );

  // Next-state counters: advance one pixel per pix_tick; the line counter
  // steps when the column wraps. >= comparisons pull stray values back to 0.
  always_comb begin
    h_nxt = hCount;
    v_nxt = vCount;
    if (pix_tick) begin
      if (hCount >= H_LAST) begin
        h_nxt = '0;
        v_nxt = (vCount >= V_LAST) ? '0 : vCount + 1'b1;
      end else begin
        h_nxt = hCount + 1'b1;
        if (vCount > V_LAST) v_nxt = '0;
      end
    end
  end

  // Counters and every decoded pin registered together on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hCount     <= '0;
      vCount     <= '0;
      hSync      <= 1'b0;
      vSync      <= 1'b0;
      bright     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hCount     <= h_nxt;
      vCount     <= v_nxt;
      hSync      <= (h_nxt >= H_SYN_C);
      vSync      <= (v_nxt >= V_SYN_C);
      bright     <= vga_timing_pkg::in_span(h_nxt, H_VS_C, H_VE_C) &&
                    vga_timing_pkg::in_span(v_nxt, V_VS_C, V_VE_C);
      frame_tick <= tick_next && (h_nxt == H_LAST) && (v_nxt == V_VE_C);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-geometry instance for reset, divider,
// sync and line-wrap timing, and a shrunken instance compared every cycle
// against a closed-form model of the scan.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int S_DIV   = 2;
  localparam int S_HT    = 10;
  localparam int S_VT    = 6;
  localparam int S_FRAME = S_DIV * S_HT * S_VT;

  logic             clk;
  logic             rst_d, rst_s;
  logic             d_pix, d_bright, d_hs, d_vs, d_ft;
  logic [CNT_W-1:0] d_h, d_v;
  logic             s_pix, s_bright, s_hs, s_vs, s_ft;
  logic [CNT_W-1:0] s_h, s_v;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m;
  logic [31:0] exp_q[$];

  vga_timing_gen u_def (
    .clk(clk), .rst(rst_d), .pix_tick(d_pix), .hCount(d_h), .vCount(d_v),
    .bright(d_bright), .hSync(d_hs), .vSync(d_vs), .frame_tick(d_ft)
  );

  vga_timing_gen #(
    .CLK_DIV(S_DIV), .H_SYNC(2), .H_VIS_START(3), .H_VIS_END(8), .H_TOTAL(S_HT),
    .V_SYNC(1), .V_VIS_START(1), .V_VIS_END(4), .V_TOTAL(S_VT)
  ) u_small (
    .clk(clk), .rst(rst_s), .pix_tick(s_pix), .hCount(s_h), .vCount(s_v),
    .bright(s_bright), .hSync(s_hs), .vSync(s_vs), .frame_tick(s_ft)
  );

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_def_reset(input string tag);
    check({tag, "_pix"},    int'(d_pix),    0);
    check({tag, "_h"},      int'(d_h),      0);
    check({tag, "_v"},      int'(d_v),      0);
    check({tag, "_hsync"},  int'(d_hs),     0);
    check({tag, "_vsync"},  int'(d_vs),     0);
    check({tag, "_bright"}, int'(d_bright), 0);
    check({tag, "_ftick"},  int'(d_ft),     0);
  endtask

  // Driver: advance the default instance one clock, sampling on negedge.
  task automatic step_def();
    @(negedge clk);
    m++;
  endtask

  initial begin : main
    int   win_h[6] = '{2, 3, 8, 9, 5, 5};
    int   win_v[6] = '{1, 1, 4, 4, 0, 5};
    int   win_b[6] = '{0, 1, 1, 0, 0, 0};
    int   exp_h8[8] = '{0, 0, 3, 1, 1, 1, 1, 2};
    int   p, hm, vm, tk, last_ft, n_ft, m_line10, n_bright, n_dft;
    bit   seen95, seen96, seen_v1, seen_v2, seen_l10;

    rst_d = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(negedge clk);
    check_def_reset("rst_def");

    // ---------------- shrunken geometry: per-cycle model compare -------------
    exp_q.push_back(32'd99);
    exp_q.push_back(32'd219);
    exp_q.push_back(32'd339);
    rst_s   = 1'b1;
    last_ft = -1;
    n_ft    = 0;
    for (int n = 0; n <= 3 * S_FRAME + 8; n++) begin
      if (n > 0) @(negedge clk);
      p  = n / S_DIV;
      hm = p % S_HT;
      vm = (p / S_HT) % S_VT;
      tk = ((n % S_DIV) == S_DIV - 1) ? 1 : 0;
      check("s_pix",    int'(s_pix),    tk);
      check("s_h",      int'(s_h),      hm);
      check("s_v",      int'(s_v),      vm);
      check("s_hsync",  int'(s_hs),     (hm >= 2) ? 1 : 0);
      check("s_vsync",  int'(s_vs),     (vm >= 1) ? 1 : 0);
      check("s_bright", int'(s_bright), (hm >= 3 && hm <= 8 && vm >= 1 && vm <= 4) ? 1 : 0);
      check("s_ftick",  int'(s_ft),     (tk == 1 && hm == 9 && vm == 4) ? 1 : 0);
      for (int i = 0; i < 6; i++)
        if (hm == win_h[i] && vm == win_v[i] && (n % S_DIV) == 0)
          check("s_win_edge", int'(s_bright), win_b[i]);
      if (s_ft) begin
        n_ft++;
        if (exp_q.size() > 0) check("s_ftick_time", n, int'(exp_q.pop_front()));
        if (last_ft >= 0) check("s_ftick_period", n - last_ft, 120);
        last_ft = n;
      end
    end
    check("s_ftick_count", n_ft, 3);
    check_def_reset("rst_def_held");

    // ---------------- default geometry: reset release and divider ------------
    rst_d = 1'b1;
    m = 0;
    for (int k = 1; k <= 8; k++) begin
      step_def();
      check("d_pix_start", int'(d_pix), (k == 3 || k == 7) ? 1 : 0);
      if (k != 3) check("d_h_start", int'(d_h), exp_h8[k-1]);
    end

    // Run to (799,10), checking sync edges on the way.
    seen95 = 0; seen96 = 0; seen_v1 = 0; seen_v2 = 0; seen_l10 = 0;
    m_line10 = -1; n_bright = 0; n_dft = 0;
    while (!(d_h == 10'd799 && d_v == 10'd10) && m < 40000) begin
      step_def();
      if (d_bright) n_bright++;
      if (d_ft) n_dft++;
      if (!seen95 && d_h == 10'd95) begin seen95 = 1; check("d_hsync_95", int'(d_hs), 0); end
      if (!seen96 && d_h == 10'd96) begin seen96 = 1; check("d_hsync_96", int'(d_hs), 1); end
      if (!seen_v1 && d_v == 10'd1) begin seen_v1 = 1; check("d_vsync_v1", int'(d_vs), 0); end
      if (!seen_v2 && d_v == 10'd2) begin seen_v2 = 1; check("d_vsync_v2", int'(d_vs), 1); end
      if (!seen_l10 && d_v == 10'd10) begin
        seen_l10 = 1;
        m_line10 = m;
        check("d_line10_start", m, 32000);
      end
    end
    check("d_reach_799_10", m, 35196);
    check("d_bright_top_rows", n_bright, 0);
    check("d_no_ftick", n_dft, 0);

    for (int k = 0; k < 8 && d_h == 10'd799; k++) step_def();
    check("d_wrap_time", m, 35200);
    check("d_wrap_h", int'(d_h), 0);
    check("d_wrap_v", int'(d_v), 11);
    check("d_wrap_hsync", int'(d_hs), 0);
    check("d_line_len", m - m_line10, 3200);

    // Mid-frame reset at (400,11) for one clock.
    while (!(d_h == 10'd400 && d_v == 10'd11) && m < 40000) step_def();
    check("d_reach_400_11", m, 36800);
    rst_d = 1'b0;
    step_def();
    check_def_reset("rst_mid");
    rst_d = 1'b1;
    m = 0;
    for (int k = 1; k <= 4; k++) begin
      step_def();
      if (k == 3) check("d_resume_pix", int'(d_pix), 1);
    end
    check("d_resume_h", int'(d_h), 1);
    check("d_resume_v", int'(d_v), 0);
    check("d_resume_hsync", int'(d_hs), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
